// File: rtl/piso_shift_tx.sv
// piso_shift_tx: valid/ready-loaded parallel-in/serial-out transmitter with an enabled shift rate.
// Define PIPO_TX_PARITY_EN to append an even-parity bit (PAR state) after the data bits.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sd,
    output logic             sd_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PIPO_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic par;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] shifted;
    logic             next_bit;
    logic             first_bit;

    // sd is registered, so the bit that will be on the line after a shift is precomputed here.
    always_comb begin
        shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
        first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            sd          <= 1'b0;
            sd_valid    <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            load_ready  <= 1'b1;
`ifdef PIPO_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state       <= SHIFT;
                        shreg       <= load_data;
                        cnt         <= '0;
                        sd          <= first_bit;
                        sd_valid    <= 1'b1;
                        frame_start <= 1'b1;
                        load_ready  <= 1'b0;
`ifdef PIPO_TX_PARITY_EN
                        par         <= ^load_data;
`endif
                    end
                end
                SHIFT: begin
                    if (en) begin
                        frame_start <= 1'b0;
                        shreg       <= shifted;
                        if (cnt == LAST) begin
                            cnt <= '0;
`ifdef PIPO_TX_PARITY_EN
                            state <= PAR;
                            sd    <= par;
`else
                            state      <= IDLE;
                            sd         <= 1'b0;
                            sd_valid   <= 1'b0;
                            load_ready <= 1'b1;
                            done       <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                            sd  <= next_bit;
                        end
                    end
                end
`ifdef PIPO_TX_PARITY_EN
                PAR: begin
                    if (en) begin
                        state      <= IDLE;
                        sd         <= 1'b0;
                        sd_valid   <= 1'b0;
                        load_ready <= 1'b1;
                        done       <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Testbench for piso_shift_tx: MSB-first and LSB-first instances driven in parallel,
// checked every cycle against a frame-queue model plus directed literal expectations.
module tb_piso_shift_tx;

    localparam int W = 8;
`ifdef PIPO_TX_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;

    logic load_ready_m, sd_m, sd_valid_m, frame_start_m, done_m;
    logic load_ready_l, sd_l, sd_valid_l, frame_start_l, done_l;

    int tests_run = 0;
    int tests_failed = 0;

    bit qm[$];
    bit ql[$];
    bit m_done = 1'b0;
    bit model_live = 1'b0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .en(en), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_m), .sd(sd_m), .sd_valid(sd_valid_m),
        .frame_start(frame_start_m), .done(done_m)
    );

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .en(en), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_l), .sd(sd_l), .sd_valid(sd_valid_l),
        .frame_start(frame_start_l), .done(done_l)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic lv, input logic [W-1:0] d, input logic e);
        reset      = r;
        load_valid = lv;
        load_data  = d;
        en         = e;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Model: a frame is a queue of bits still to be sent; each enabled edge consumes one.
    always @(posedge clk) begin
        if (!reset) begin
            qm.delete();
            ql.delete();
            m_done = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            m_done = 1'b0;
            if (qm.size() == 0) begin
                if (load_valid) begin
                    for (int i = 0; i < W; i++) begin
                        qm.push_back(load_data[W-1-i]);
                        ql.push_back(load_data[i]);
                    end
`ifdef PIPO_TX_PARITY_EN
                    qm.push_back(^load_data);
                    ql.push_back(^load_data);
`endif
                end
            end else if (en) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
                if (qm.size() == 0) m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("load_ready_msb", load_ready_m, qm.size() == 0);
            checkOutput("sd_valid_msb", sd_valid_m, qm.size() != 0);
            checkOutput("sd_msb", sd_m, (qm.size() != 0) ? qm[0] : 1'b0);
            checkOutput("frame_start_msb", frame_start_m, qm.size() == FLEN);
            checkOutput("done_msb", done_m, m_done);
            checkOutput("load_ready_lsb", load_ready_l, ql.size() == 0);
            checkOutput("sd_valid_lsb", sd_valid_l, ql.size() != 0);
            checkOutput("sd_lsb", sd_l, (ql.size() != 0) ? ql[0] : 1'b0);
            checkOutput("frame_start_lsb", frame_start_l, ql.size() == FLEN);
            checkOutput("done_lsb", done_l, m_done);
        end
    end

    // Call right after the accepting edge; runs the whole frame with en=1 plus the done cycle.
    task automatic captureFrame(output logic [31:0] bits_m, output logic [31:0] bits_l,
                                output int fs_count, output int done_at);
        bits_m   = '0;
        bits_l   = '0;
        fs_count = 0;
        done_at  = 0;
        for (int c = 1; c <= FLEN + 1; c++) begin
            @(negedge clk);
            if (c <= FLEN) begin
                bits_m = {bits_m[30:0], sd_m};
                bits_l = {bits_l[30:0], sd_l};
            end
            if (frame_start_m) fs_count++;
            if (done_m && done_at == 0) done_at = c;
            nextCycle();
        end
    endtask

    logic [31:0] bm, bl, seq_m, seq_l;
    int fs, dn, vcount, zeros, ones;

    initial begin
        // Reset held two edges with load_valid and en active
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b1);
        repeat (2) nextCycle();
        @(negedge clk);
        checkOutput("reset_load_ready", load_ready_m, 1);
        checkOutput("reset_sd", sd_m, 0);
        checkOutput("reset_sd_valid", sd_valid_m, 0);
        checkOutput("reset_done", done_m, 0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        nextCycle();

        // 8'hA5 with en constantly high
        applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        captureFrame(bm, bl, fs, dn);
        checkOutput("a5_bits_msb", bm >> (FLEN - W), 32'hA5);
        checkOutput("a5_bits_lsb", bl >> (FLEN - W), 32'hA5);
        checkOutput("a5_frame_start_count", fs, 1);
        checkOutput("a5_done_cycle", dn, FLEN + 1);
        nextCycle();

        // 8'h01 with en toggling: every bit held two clocks
        applyStimulus(1'b1, 1'b1, 8'h01, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        seq_m = '0;
        seq_l = '0;
        vcount = 0;
        for (int c = 0; c < 2 * FLEN; c++) begin
            en = (c % 2) != 0;
            @(negedge clk);
            seq_m = {seq_m[30:0], sd_m};
            seq_l = {seq_l[30:0], sd_l};
            if (sd_valid_l) vcount++;
            nextCycle();
        end
        en = 1'b1;
        @(negedge clk);
        checkOutput("toggle_done", done_l, 1);
        checkOutput("toggle_valid_cycles", vcount, 2 * FLEN);
`ifdef PIPO_TX_PARITY_EN
        checkOutput("toggle_seq_lsb", seq_l, 32'h30003);
        checkOutput("toggle_seq_msb", seq_m, 32'h0000F);
`else
        checkOutput("toggle_seq_lsb", seq_l, 32'hC000);
        checkOutput("toggle_seq_msb", seq_m, 32'h0003);
`endif
        nextCycle();
        nextCycle();

        // Back-to-back: load_valid held high through both frames
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
        nextCycle();
        load_data = 8'h00;
        zeros = 0;
        ones = 0;
        dn = 0;
        for (int c = 1; c <= 2 * FLEN + 1; c++) begin
            @(negedge clk);
            if (!sd_valid_m) zeros++;
            if (sd_m) ones++;
            if (done_m && dn == 0) dn = c;
            nextCycle();
        end
        load_valid = 1'b0;
        checkOutput("b2b_gap_cycles", zeros, 1);
        checkOutput("b2b_ones", ones, 8);
        checkOutput("b2b_first_done", dn, FLEN + 1);
        repeat (3) nextCycle();

        // Reset mid-frame, then a clean frame
        applyStimulus(1'b1, 1'b1, 8'hC3, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        repeat (3) nextCycle();
        reset = 1'b0;
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_load_ready", load_ready_m, 1);
        checkOutput("abort_sd_valid", sd_valid_m, 0);
        checkOutput("abort_done", done_m, 0);
        load_valid = 1'b1;
        load_data = 8'h3C;
        nextCycle();
        load_valid = 1'b0;
        captureFrame(bm, bl, fs, dn);
        checkOutput("after_abort_bits_msb", bm >> (FLEN - W), 32'h3C);
        checkOutput("after_abort_bits_lsb", bl >> (FLEN - W), 32'h3C);
        checkOutput("after_abort_done_cycle", dn, FLEN + 1);

`ifdef PIPO_TX_PARITY_EN
        applyStimulus(1'b1, 1'b1, 8'h07, 1'b1);
        nextCycle();
        load_valid = 1'b0;
        captureFrame(bm, bl, fs, dn);
        checkOutput("par07_bits", bm, 32'h00F);
        checkOutput("par07_done_cycle", dn, 10);
        applyStimulus(1'b1, 1'b1, 8'h03, 1'b1);
        nextCycle();
        load_valid = 1'b0;
        captureFrame(bm, bl, fs, dn);
        checkOutput("par03_bits", bm, 32'h006);
`endif

        repeat (2) nextCycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
